// File: rtl/booth_mult_arbiter_if.sv
// Request/response bundle for the shared Booth multiplier.
// master drives requests and consumes responses; slave is the arbiter side.
interface booth_mult_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_multiplicand;
  logic [NUM_REQ*WIDTH-1:0] req_multiplier;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_product;

  modport master (
    output req_valid, req_multiplicand, req_multiplier, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_multiplicand, req_multiplier, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one combinational radix-4 Booth multiplier.
// Operands are held in registers for LATENCY cycles (multicycle path), then
// the product is captured into the response register. One op in flight.
module booth_mult_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  booth_mult_arbiter_if.slave bus,
  output logic                busy
);
  localparam int unsigned ProdW     = 2 * WIDTH;
  // Multiplier widened to an even bit count so every Booth group is complete.
  localparam int unsigned YExtW     = WIDTH + (WIDTH % 2);
  localparam int unsigned NumGroups = YExtW / 2;
  localparam int unsigned CntW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q;
  logic [ID_W-1:0]          id_q;
  logic [CntW-1:0]          cnt_q;
  logic signed [WIDTH-1:0]  mcand_q;
  logic signed [WIDTH-1:0]  mplier_q;
  logic                     rsp_valid_q;
  logic [ID_W-1:0]          rsp_id_q;
  logic [ProdW-1:0]         rsp_product_q;

  logic                     gnt_any;
  logic [ID_W-1:0]          gnt_idx;
  int unsigned              scan_idx;

  logic signed [ProdW-1:0]  mcand_ext;
  logic signed [ProdW-1:0]  pp;
  logic signed [ProdW-1:0]  prod;
  logic [YExtW:0]           y_ext;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!gnt_any && bus.req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(scan_idx);
      end
    end
  end

  // Radix-4 Booth multiplier; sums wrap mod 2^ProdW, which is exact because
  // the true product always fits in ProdW bits.
  always_comb begin
    mcand_ext = ProdW'(mcand_q);
    y_ext     = {YExtW'(mplier_q), 1'b0};
    pp        = '0;
    prod      = '0;
    for (int unsigned g = 0; g < NumGroups; g++) begin
      unique case (y_ext[2*g +: 3])
        3'b001, 3'b010: pp = mcand_ext;
        3'b011:         pp = mcand_ext <<< 1;
        3'b100:         pp = -(mcand_ext <<< 1);
        3'b101, 3'b110: pp = -mcand_ext;
        3'b000, 3'b111: pp = '0;
        default:        pp = '0;
      endcase
      prod = prod + (pp <<< (2 * g));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_any) state_d = StBusy;
      StBusy:  if (cnt_q == '0) state_d = StDone;
      StDone:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: grant only while idle, response straight from registers.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && gnt_any) bus.req_ready[gnt_idx] = 1'b1;
    busy            = (state_q != StIdle);
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_id      = rsp_id_q;
    bus.rsp_product = rsp_product_q;
  end

  // Datapath: capture operands on accept, count down, capture product.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            mcand_q  <= bus.req_multiplicand[gnt_idx*WIDTH +: WIDTH];
            mplier_q <= bus.req_multiplier[gnt_idx*WIDTH +: WIDTH];
            id_q     <= gnt_idx;
            rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt_q    <= CntW'(LATENCY - 1);
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_product_q <= prod;
            rsp_id_q      <= id_q;
            rsp_valid_q   <= 1'b1;
          end
        end
        StDone: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Scoreboard bench for booth_mult_arbiter: expected products are pushed on
// each accepted request and popped when the response handshake completes.
module tb_booth_mult_arbiter;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned LATENCY = 2;

  typedef struct {
    int unsigned   id;
    logic [63:0]   prod;
    int            acc_edge;
  } exp_t;

  typedef struct {
    int unsigned id;
    int          acc_edge;
  } acc_t;

  typedef struct {
    int unsigned id;
    logic [63:0] prod;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];
  acc_t acc_log[$];
  rsp_t rsp_log[$];
  exp_t sb_e;
  logic rsp_valid_prev = 1'b0;
  logic [63:0] last_prod;
  int unsigned last_id;

  booth_mult_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  booth_mult_arbiter #(
    .WIDTH  (WIDTH),
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .LATENCY(LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_mul(input logic signed [WIDTH-1:0] a,
                                            input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] r;
    r = a * b;
    return r;
  endfunction

  // Response side first (pop), then request side (push), at each falling edge.
  always @(negedge clk) begin
    if (rst) begin
      rsp_valid_prev = 1'b0;
    end else begin
      if (bus.rsp_valid && !rsp_valid_prev && sb_q.size() > 0)
        check_eq("latency", 64'(cyc - sb_q[0].acc_edge), 64'(LATENCY));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          sb_e = sb_q.pop_front();
          check_eq("rsp_id", 64'(bus.rsp_id), 64'(sb_e.id));
          check_eq("rsp_product", bus.rsp_product, sb_e.prod);
          last_prod = bus.rsp_product;
          last_id   = bus.rsp_id;
          rsp_log.push_back('{id: bus.rsp_id, prod: bus.rsp_product});
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.req_valid[k] && bus.req_ready[k]) begin
          sb_q.push_back('{id: k,
                           prod: model_mul(bus.req_multiplicand[k*WIDTH +: WIDTH],
                                           bus.req_multiplier[k*WIDTH +: WIDTH]),
                           acc_edge: cyc + 1});
          acc_log.push_back('{id: k, acc_edge: cyc + 1});
        end
      end
      rsp_valid_prev = bus.rsp_valid;
    end
  end

  task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_multiplicand[k*WIDTH +: WIDTH] = a;
    bus.req_multiplier[k*WIDTH +: WIDTH]   = b;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_ready(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("ready_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_accepts(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_log.size() >= n) break;
    end
  endtask

  task automatic do_op(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    @(posedge clk); #1;
    set_ops(k, a, b);
    bus.req_valid[k] = 1'b1;
    wait_ready(k, ok);
    if (ok) @(posedge clk);
    #1 bus.req_valid[k] = 1'b0;
    wait_drain(50);
  endtask

  logic [63:0] four_exp [5];
  int unsigned four_id  [5];
  bit          ok;

  initial begin
    four_exp = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd2};
    four_id  = '{0, 1, 2, 3, 0};
    bus.req_valid        = '0;
    bus.req_multiplicand = '0;
    bus.req_multiplier   = '0;
    bus.rsp_ready        = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check_eq("rst_rsp_product", bus.rsp_product, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);

    // Single requester 3 * -5.
    @(posedge clk); #1;
    set_ops(0, 32'd3, -32'sd5);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check_eq("single_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1 bus.req_valid = '0;
    @(negedge clk);
    check_eq("single_busy", 64'(busy), 64'd1);
    wait_drain(20);
    check_eq("single_prod", last_prod, 64'hFFFF_FFFF_FFFF_FFF1);
    check_eq("single_id", 64'(last_id), 64'd0);

    // All four requesters continuously valid.
    apply_reset();
    acc_log.delete();
    rsp_log.delete();
    for (int k = 0; k < NUM_REQ; k++) set_ops(k, WIDTH'(k + 1), WIDTH'(k + 2));
    bus.req_valid = 4'b1111;
    wait_accepts(5);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_drain(50);
    check_eq("four_accepts", 64'(acc_log.size()), 64'd5);
    check_eq("four_rsps", 64'(rsp_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < acc_log.size(); i++) begin
      check_eq("four_grant", 64'(acc_log[i].id), 64'(four_id[i]));
      if (i > 0) check_eq("four_spacing", 64'(acc_log[i].acc_edge - acc_log[i-1].acc_edge),
                          64'(LATENCY + 2));
    end
    for (int i = 0; i < 5 && i < rsp_log.size(); i++)
      check_eq("four_prod", rsp_log[i].prod, four_exp[i]);

    // Extremes.
    do_op(1, 32'h8000_0000, 32'h8000_0000);
    check_eq("min_x_min", last_prod, 64'h4000_0000_0000_0000);
    do_op(2, 32'h8000_0000, 32'h7FFF_FFFF);
    check_eq("min_x_max", last_prod, 64'hC000_0000_8000_0000);
    do_op(3, 32'h0, 32'h1234_5678);
    check_eq("zero_x_n", last_prod, 64'd0);
    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("neg1_x_neg1", last_prod, 64'd1);

    // Random operands through the scoreboard.
    for (int i = 0; i < 16; i++)
      do_op(int'($urandom_range(NUM_REQ - 1)), $urandom, $urandom);

    // Backpressure: response held, no grants, then round-robin resumes at 1.
    apply_reset();
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) set_ops(k, WIDTH'(k + 10), -WIDTH'(k + 1));
    bus.req_valid = 4'b1111;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("bp_rsp_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(bus.rsp_valid), 64'd1);
      check_eq("bp_id", 64'(bus.rsp_id), 64'd0);
      check_eq("bp_prod", bus.rsp_product, 64'hFFFF_FFFF_FFFF_FFF6);
      check_eq("bp_ready", 64'(bus.req_ready), 64'd0);
    end
    acc_log.delete();
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_accepts(1);
    @(posedge clk); #1 bus.req_valid = '0;
    check_eq("bp_next_n", 64'(acc_log.size() >= 1), 64'd1);
    if (acc_log.size() >= 1) check_eq("bp_next_grant", 64'(acc_log[0].id), 64'd1);
    wait_drain(50);

    // Operand change after accept has no effect on the in-flight op.
    acc_log.delete();
    rsp_log.delete();
    @(posedge clk); #1;
    set_ops(2, 32'd7, 32'd6);
    bus.req_valid = 4'b0100;
    wait_ready(2, ok);
    @(posedge clk); #1 set_ops(2, 32'd99, 32'd99);
    wait_accepts(2);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_drain(50);
    check_eq("opchg_rsps", 64'(rsp_log.size()), 64'd2);
    if (rsp_log.size() >= 2) begin
      check_eq("opchg_first", rsp_log[0].prod, 64'd42);
      check_eq("opchg_second", rsp_log[1].prod, 64'd9801);
    end

    // Reset while busy abandons the op and clears rr_ptr.
    @(posedge clk); #1;
    set_ops(1, 32'd5, 32'd5);
    bus.req_valid = 4'b0010;
    wait_ready(1, ok);
    @(posedge clk); #1 bus.req_valid = '0;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    rsp_log.delete();
    @(posedge clk); #1;
    set_ops(0, 32'd2, 32'd2);
    set_ops(2, 32'd2, 32'd2);
    bus.req_valid = 4'b0101;
    @(negedge clk);
    check_eq("mid_rst_rrptr", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_drain(50);
    repeat (10) @(negedge clk);
    check_eq("mid_rst_rsps", 64'(rsp_log.size()), 64'd1);
    if (rsp_log.size() >= 1) begin
      check_eq("mid_rst_prod", rsp_log[0].prod, 64'd4);
      check_eq("mid_rst_id", 64'(rsp_log[0].id), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/booth_mult_arbiter.md
Name: booth_mult_arbiter

Overview:
- Shares one combinational signed Booth multiplier instance (WIDTH x WIDTH -> 2*WIDTH) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on each request port; one shared response channel tagged with the requester ID.
- Operands are registered and held stable for LATENCY cycles, so the multiplier is constrained as a LATENCY-cycle multicycle path.
- Non-pipelined: at most one operation in flight.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- NUM_REQ, 4, number of requesters, >= 2.
- ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.
- LATENCY, 2, cycles operands are held before the product is captured, >= 1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- req_valid, input, NUM_REQ, per-requester request valid.
- req_ready, output, NUM_REQ, per-requester accept; at most one bit high.
- req_multiplicand, input, NUM_REQ*WIDTH, packed operands; requester k uses bits [k*WIDTH +: WIDTH]; signed.
- req_multiplier, input, NUM_REQ*WIDTH, packed as above; signed.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumer ready.
- rsp_id, output, ID_W, index of the requester that owns rsp_product.
- rsp_product, output, 2*WIDTH, signed product.
- busy, output, 1, high in BUSY or DONE.

Behaviour:
- Reset values: state = IDLE; rsp_valid = 0; rsp_id = 0; rsp_product = 0; rr_ptr = 0; busy = 0; req_ready = 0; operand registers = 0.
- Reset mid-operation abandons the in-flight op; no response is ever produced for it.
- FSM states: IDLE, BUSY, DONE.

IDLE:
- Grant goes to the first requester with req_valid high, searching from rr_ptr upward with wrap-around modulo NUM_REQ.
- req_ready[grant] is driven combinationally high only in IDLE and only when some req_valid is high; all other bits are 0.
- A transfer occurs when req_valid[g] & req_ready[g] at a clock edge. On that edge:
  - capture the operands and the grant ID;
  - rr_ptr <= (g+1) mod NUM_REQ;
  - cnt <= LATENCY-1;
  - go to BUSY.
- With no req_valid high: stay in IDLE; rr_ptr is unchanged.

BUSY:
- req_ready = 0.
- Operand registers feed the multiplier and stay stable.
- If cnt != 0: cnt decrements.
- If cnt == 0: rsp_product <= multiplier output, rsp_id <= captured ID, rsp_valid <= 1, go to DONE.

DONE:
- rsp_valid = 1; rsp_product and rsp_id are held stable.
- On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE.
- No same-cycle bypass: the next request can be accepted no earlier than the cycle after the handshake.

Latency and throughput:
- Accept edge at cycle T: rsp_valid rises after the edge at T+LATENCY.
- With rsp_ready held high: one op per LATENCY+2 cycles.

Arithmetic:
- Two's-complement signed product, exact in 2*WIDTH bits, no truncation.
- Operand -2^(WIDTH-1) is handled correctly.

Other rules:
- A requester's req_valid dropping while it is not granted is legal; this block imposes no hold requirement.
- Operands are sampled only on the accept edge; later changes on req_* have no effect on the in-flight op.
- Backpressure: rsp_ready low holds DONE indefinitely, and all requesters see req_ready = 0.

Test Plan:
- Reset, single requester: req_valid=4'b0001, multiplicand=3, multiplier=-5 (WIDTH=32, LATENCY=2) -> req_ready[0] high in cycle 0; rsp_valid high 2 cycles after the accept; rsp_id=0; rsp_product=64'hFFFF_FFFF_FFFF_FFF1.
- All four requesters valid continuously, rsp_ready=1, requester k sends (k+1)*(k+2) -> grants in order 0,1,2,3,0; products 2,6,12,20; accepts 4 cycles apart.
- Extremes: 32'h8000_0000 * 32'h8000_0000 -> 64'h4000_0000_0000_0000; 32'h8000_0000 * 32'h7FFF_FFFF -> 64'hC000_0000_8000_0000; 0 * 32'h1234_5678 -> 0.
- Backpressure: rsp_ready=0 for 10 cycles while req_valid=4'b1111 -> rsp_valid/rsp_id/rsp_product stable and req_ready=0 throughout; after rsp_ready=1 the next grant goes to rr_ptr.
- Operand change after accept: accept 7*6, then drive 99*99 on the same port during BUSY -> rsp_product=42.
- Reset mid-op: assert rst in the BUSY cycle -> next cycle rsp_valid=0, busy=0, rr_ptr=0, and no response for that op ever appears; a new request (2*2) afterwards returns 4 with rsp_id correct.
